// File: rtl/serial_divisibility_checker_pkg.sv
// Shared definitions for the serial divisibility checker: bit-order modes and
// the helper that sizes the remainder/weight registers from the divisor.
package serial_divisibility_checker_pkg;

  // Bit-order mode latched at frame start
  typedef enum logic {
    MODE_MSB = 1'b0,
    MODE_LSB = 1'b1
  } mode_e;

  // Width needed to hold a value in 0..divisor-1, never narrower than one bit
  function automatic int calc_rw(input int divisor);
    return (divisor <= 2) ? 1 : $clog2(divisor);
  endfunction

endpackage

// File: rtl/serial_divisibility_checker_if.sv
// Serial bit stream in, running divisibility status out.
interface serial_divisibility_checker_if #(
  parameter int RW    = 2,
  parameter int CNT_W = 8
);
  logic             in;
  logic             in_valid;
  logic             start;
  logic             lsb_first;
  logic             multiple_of_n;
  logic [RW-1:0]    remainder;
  logic [CNT_W-1:0] bit_count;
  logic             out_valid;
  logic             overflow;

  modport master (
    output in, in_valid, start, lsb_first,
    input  multiple_of_n, remainder, bit_count, out_valid, overflow
  );

  modport slave (
    input  in, in_valid, start, lsb_first,
    output multiple_of_n, remainder, bit_count, out_valid, overflow
  );
endinterface

// File: rtl/serial_divisibility_checker_mod_n_add.sv
// Modular adder: y = (a + b + cin) mod N for a, b < N, using one conditional
// subtract. The sum is at most 2N-1, so one subtraction always suffices.
module mod_n_add #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] y
);
  localparam logic [W:0] N_EXT = N[W:0];

  logic [W:0] sum;
  logic [W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign diff = sum - N_EXT;
  assign y    = (sum >= N_EXT) ? diff[W-1:0] : sum[W-1:0];
endmodule

// File: rtl/serial_divisibility_checker.sv
// Tracks the value of a serial frame modulo DIVISOR without a divider.
// MSB-first frames use r' = 2r + b; LSB-first frames add b * 2^k, keeping the
// power-of-two weight reduced mod N alongside the remainder.
module serial_divisibility_checker
  import serial_divisibility_checker_pkg::*;
#(
  parameter int DIVISOR = 4,
  parameter int CNT_W   = 8,
  parameter int RW      = calc_rw(DIVISOR)
) (
  input logic                          clk,
  input logic                          reset,
  serial_divisibility_checker_if.slave bus
);
  localparam logic [RW-1:0]    W_INIT   = RW'(1 % DIVISOR);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_NEAR = CNT_MAX - CNT_ONE;

  logic [RW-1:0]    r_q, w_q;
  logic [CNT_W-1:0] cnt_q;
  mode_e            mode_q;
  logic             mult_q, valid_q, ovf_q;

  logic [RW-1:0]    base_r, base_w, add_b, r_next, w_next;
  logic [CNT_W-1:0] base_cnt, cnt_next;
  mode_e            base_mode;
  logic             base_ovf, add_cin, ovf_next;

  // Frame state to build on: a start restarts the frame even when a bit arrives
  always_comb begin
    base_r    = bus.start ? '0 : r_q;
    base_w    = bus.start ? W_INIT : w_q;
    base_mode = bus.start ? mode_e'(bus.lsb_first) : mode_q;
    base_cnt  = bus.start ? '0 : cnt_q;
    base_ovf  = bus.start ? 1'b0 : ovf_q;
    add_b     = (base_mode == MODE_MSB) ? base_r : (bus.in ? base_w : '0);
    add_cin   = (base_mode == MODE_MSB) & bus.in;
    cnt_next  = (base_cnt == CNT_MAX) ? base_cnt : base_cnt + CNT_ONE;
    ovf_next  = base_ovf | (base_cnt >= CNT_NEAR);
  end

  mod_n_add #(.N(DIVISOR), .W(RW)) u_rem_add (
    .a   (base_r),
    .b   (add_b),
    .cin (add_cin),
    .y   (r_next)
  );

  mod_n_add #(.N(DIVISOR), .W(RW)) u_wgt_add (
    .a   (base_w),
    .b   (base_w),
    .cin (1'b0),
    .y   (w_next)
  );

  // Registered frame state and outputs; idle cycles hold everything but out_valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q     <= '0;
      w_q     <= W_INIT;
      cnt_q   <= '0;
      mode_q  <= MODE_MSB;
      mult_q  <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (bus.in_valid) begin
      r_q     <= r_next;
      w_q     <= (base_mode == MODE_LSB) ? w_next : base_w;
      cnt_q   <= cnt_next;
      mode_q  <= base_mode;
      mult_q  <= (r_next == '0) && (cnt_next != '0);
      valid_q <= 1'b1;
      ovf_q   <= ovf_next;
    end else if (bus.start) begin
      r_q     <= '0;
      w_q     <= W_INIT;
      cnt_q   <= '0;
      mode_q  <= mode_e'(bus.lsb_first);
      mult_q  <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign bus.remainder     = r_q;
  assign bus.bit_count     = cnt_q;
  assign bus.multiple_of_n = mult_q;
  assign bus.out_valid     = valid_q;
  assign bus.overflow      = ovf_q;
endmodule

// File: tb/tb_serial_divisibility_checker.sv
// Drives one shared bit stream into four checker instances with different
// divisors and counter widths; a reference model predicts each accepted bit
// and a monitor compares the DUT outputs whenever out_valid is seen.
module tb_serial_divisibility_checker;
  import serial_divisibility_checker_pkg::*;

  localparam int NUM = 4;
  localparam int NS  [NUM] = '{4, 3, 5, 1};
  localparam int CWS [NUM] = '{8, 8, 2, 3};

  typedef struct {
    int rem;
    int mult;
    int cnt;
    int ovf;
  } exp_t;

  logic clk, reset;
  logic s_in, s_valid, s_start, s_lsb;
  logic [7:0] obs_rem [NUM];
  logic [7:0] obs_cnt [NUM];
  logic obs_mult [NUM];
  logic obs_valid [NUM];
  logic obs_ovf [NUM];

  int tests = 0;
  int fails = 0;

  bit   frame [$];
  bit   frame_lsb = 1'b0;
  exp_t exp_q [NUM][$];
  exp_t mon_e;

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < NUM; g++) begin : g_dut
    localparam int N   = NS[g];
    localparam int CW  = CWS[g];
    localparam int RWG = calc_rw(N);

    serial_divisibility_checker_if #(.RW(RWG), .CNT_W(CW)) bus ();

    assign bus.in        = s_in;
    assign bus.in_valid  = s_valid;
    assign bus.start     = s_start;
    assign bus.lsb_first = s_lsb;
    assign obs_rem[g]    = 8'(bus.remainder);
    assign obs_cnt[g]    = 8'(bus.bit_count);
    assign obs_mult[g]   = bus.multiple_of_n;
    assign obs_valid[g]  = bus.out_valid;
    assign obs_ovf[g]    = bus.overflow;

    serial_divisibility_checker #(.DIVISOR(N), .CNT_W(CW), .RW(RWG)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
    );
  end

  // Value of the bits received so far, reduced mod n, in the given bit order
  function automatic int frame_mod(input int n, input bit lsb);
    int v = 0;
    int p = 1 % n;
    foreach (frame[i]) begin
      if (lsb) begin
        v = (v + frame[i] * p) % n;
        p = (p * 2) % n;
      end else begin
        v = (v * 2 + frame[i]) % n;
      end
    end
    return v;
  endfunction

  task automatic checkOutput(input string name, input int d, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s dut%0d (N=%0d): got %0d, expected %0d at %0t",
               name, d, NS[d], act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at a falling edge and return at the next one
  task automatic applyStimulus(input bit b, input bit v, input bit s, input bit l);
    s_in    = b;
    s_valid = v;
    s_start = s;
    s_lsb   = l;
    @(negedge clk);
  endtask

  task automatic checkCleared(input string name);
    for (int d = 0; d < NUM; d++) begin
      checkOutput({name, "_rem"}, d, obs_rem[d], 0);
      checkOutput({name, "_cnt"}, d, obs_cnt[d], 0);
      checkOutput({name, "_mult"}, d, obs_mult[d], 0);
      checkOutput({name, "_valid"}, d, obs_valid[d], 0);
      checkOutput({name, "_ovf"}, d, obs_ovf[d], 0);
    end
  endtask

  // Reference model: record each accepted bit and queue the expected outputs
  always @(posedge clk) begin
    if (!reset) begin
      frame.delete();
      frame_lsb <= 1'b0;
    end else begin
      automatic bit lsb_now = s_start ? s_lsb : frame_lsb;
      if (s_start) begin
        frame.delete();
        frame_lsb <= s_lsb;
      end
      if (s_valid) begin
        frame.push_back(s_in);
        for (int d = 0; d < NUM; d++) begin
          automatic int   cmax = (1 << CWS[d]) - 1;
          automatic int   raw  = frame.size();
          automatic exp_t e;
          e.rem  = frame_mod(NS[d], lsb_now);
          e.mult = (e.rem == 0) ? 1 : 0;
          e.cnt  = (raw < cmax) ? raw : cmax;
          e.ovf  = (raw >= cmax) ? 1 : 0;
          exp_q[d].push_back(e);
        end
      end
    end
  end

  // Monitor: every out_valid consumes one prediction per instance
  always @(negedge clk) begin
    for (int d = 0; d < NUM; d++) begin
      if (obs_valid[d]) begin
        if (exp_q[d].size() == 0) begin
          checkOutput("unexpected_out_valid", d, 1, 0);
        end else begin
          mon_e = exp_q[d].pop_front();
          checkOutput("sb_remainder", d, obs_rem[d], mon_e.rem);
          checkOutput("sb_multiple", d, obs_mult[d], mon_e.mult);
          checkOutput("sb_bit_count", d, obs_cnt[d], mon_e.cnt);
          checkOutput("sb_overflow", d, obs_ovf[d], mon_e.ovf);
        end
      end
    end
  end

  initial begin
    int b030 [4] = '{1, 1, 0, 0};
    int r030 [4] = '{1, 3, 2, 0};
    int m030 [4] = '{0, 0, 0, 1};
    int b031 [3] = '{1, 1, 0};
    int r031 [3] = '{1, 0, 0};
    int m031 [3] = '{0, 1, 1};
    int b032 [3] = '{0, 1, 1};
    int r032 [3] = '{0, 2, 0};
    int m032 [3] = '{1, 0, 1};
    int c035 [5] = '{1, 2, 3, 3, 3};
    int o035 [5] = '{0, 0, 1, 1, 1};

    reset   = 1'b0;
    s_in    = 1'b0;
    s_valid = 1'b0;
    s_start = 1'b0;
    s_lsb   = 1'b0;
    @(negedge clk);
    checkCleared("reset_state");
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0);

    // N=4 MSB-first 1,1,0,0
    for (int i = 0; i < 4; i++) begin
      applyStimulus(b030[i][0], 1, i == 0, 0);
      checkOutput("msb_n4_rem", 0, obs_rem[0], r030[i]);
      checkOutput("msb_n4_mult", 0, obs_mult[0], m030[i]);
    end

    // N=3 MSB-first 1,1,0
    for (int i = 0; i < 3; i++) begin
      applyStimulus(b031[i][0], 1, i == 0, 0);
      checkOutput("msb_n3_rem", 1, obs_rem[1], r031[i]);
      checkOutput("msb_n3_mult", 1, obs_mult[1], m031[i]);
    end

    // N=3 LSB-first 0,1,1 (value 6); lsb_first dropped after start must be ignored
    for (int i = 0; i < 3; i++) begin
      applyStimulus(b032[i][0], 1, i == 0, i == 0);
      checkOutput("lsb_n3_rem", 1, obs_rem[1], r032[i]);
      checkOutput("lsb_n3_mult", 1, obs_mult[1], m032[i]);
      checkOutput("div1_rem", 3, obs_rem[3], 0);
      checkOutput("div1_mult", 3, obs_mult[3], 1);
    end

    // Start without data right after a divisible frame
    applyStimulus(0, 0, 1, 0);
    for (int d = 0; d < NUM; d++) begin
      checkOutput("start_idle_mult", d, obs_mult[d], 0);
      checkOutput("start_idle_cnt", d, obs_cnt[d], 0);
    end

    // Idle cycle holds state and drops out_valid
    applyStimulus(1, 0, 0, 1);
    checkOutput("idle_valid", 0, obs_valid[0], 0);

    // Reset mid-frame, then a fresh frame begins without start
    applyStimulus(1, 1, 1, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    reset = 1'b0;
    #1;
    checkCleared("async_reset");
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1, 1, 0, 0);
    checkOutput("post_reset_rem", 0, obs_rem[0], 1);
    checkOutput("post_reset_cnt", 0, obs_cnt[0], 1);

    // Counter saturation on the CNT_W=2 instance
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, i == 0, 0);
      checkOutput("sat_cnt", 2, obs_cnt[2], c035[i]);
      checkOutput("sat_ovf", 2, obs_ovf[2], o035[i]);
    end
    applyStimulus(0, 0, 0, 0);
    checkOutput("sat_ovf_hold", 2, obs_ovf[2], 1);
    applyStimulus(0, 0, 1, 0);
    checkOutput("start_clears_ovf", 2, obs_ovf[2], 0);
    checkOutput("start_clears_cnt", 2, obs_cnt[2], 0);

    // Random traffic: gaps, restarts, and lsb_first toggling mid-frame
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 1), $urandom_range(0, 9) < 7,
                    $urandom_range(0, 19) == 0, $urandom_range(0, 1));
    end

    repeat (3) applyStimulus(0, 0, 0, 0);
    for (int d = 0; d < NUM; d++) begin
      checkOutput("pending_predictions", d, exp_q[d].size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_divisibility_checker.md
SERIAL_DIVISIBILITY_CHECKER -- requirements
Module: serial_divisibility_checker

Interface
REQ-001 The block SHALL have parameter DIVISOR, default 4, meaning the divisor N; legal range 1..255.
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of the accepted-bit counter.
REQ-003 The block SHALL have parameter RW, default max(1, clog2(DIVISOR)), meaning the width of the remainder and weight registers.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1 bit: reset SHALL be asynchronous and active-low.
REQ-006 Port in, input, 1 bit: the serial data bit.
REQ-007 Port in_valid, input, 1 bit: when high, in is accepted on that clock edge.
REQ-008 Port start, input, 1 bit: frame start; it SHALL clear the frame state (see REQ-014).
REQ-009 Port lsb_first, input, 1 bit: bit-order mode; 0 = MSB-first, 1 = LSB-first; it SHALL be sampled only when start=1.
REQ-010 Port multiple_of_n, output, 1 bit: the frame value received so far is divisible by DIVISOR.
REQ-011 Port remainder, output, RW bits: the frame value mod DIVISOR.
REQ-012 Port bit_count, output, CNT_W bits: the number of bits accepted in the current frame.
REQ-013 Port out_valid, output, 1 bit: pulses high one cycle after each accepted bit; overflow, output, 1 bit: sticky flag set when bit_count saturates.

Function
REQ-014 When start=1 and in_valid=0, the block SHALL set r=0, w=1 mod N and bit_count=0, latch the mode, and drive multiple_of_n=0.
REQ-015 When start=1 and in_valid=1, the block SHALL treat in as the first bit of a new frame, computed from r=0 and w=1 mod N.
REQ-016 In MSB-first mode, each accepted bit b SHALL update r' = (2r + b) mod N.
REQ-017 In LSB-first mode, each accepted bit b SHALL update r' = (r + b*w) mod N and w' = (2w) mod N.
REQ-018 All modular reductions SHALL use a single conditional subtract of N (operands < 2N); no divider SHALL be used.
REQ-019 Outputs SHALL be registered with 1-cycle latency: the edge that accepts bit k SHALL present the post-bit-k values on the outputs.
REQ-020 multiple_of_n SHALL equal (r == 0) AND (bit_count > 0); an empty frame SHALL NOT report as divisible.
REQ-021 If DIVISOR=1, multiple_of_n SHALL be 1 after every accepted bit, and remainder SHALL be 0.
REQ-022 bit_count SHALL saturate at 2^CW-1; the saturating increment SHALL set overflow, which SHALL stay set until start or reset, while r keeps updating.
REQ-023 When in_valid=0 and start=0, all state SHALL hold, and out_valid SHALL be 0.
REQ-024 A change on lsb_first mid-frame SHALL be ignored until the next start.

Reset
REQ-025 Asserting reset (reset=0) SHALL immediately force r=0, w=1 mod N, bit_count=0, mode=MSB-first, multiple_of_n=0, out_valid=0 and overflow=0.
REQ-026 Reset asserted mid-frame SHALL discard the frame; the first bit accepted after release SHALL start a new frame.

Structure
REQ-027 A shared package/header SHALL hold the width function for RW and the mode constants MODE_MSB=0 and MODE_LSB=1.
REQ-028 The block SHALL contain one sub-module, mod_n_add, performing (a+b) mod N by conditional subtract.
REQ-029 mod_n_add SHALL be instantiated for the remainder update and for the weight update.

Verification
REQ-030 Scenario: N=4, MSB-first, bits 1,1,0,0 -> remainder 1,3,2,0; multiple_of_n 0,0,0,1.
REQ-031 Scenario: N=3, MSB-first, bits 1,1,0 -> remainder 1,0,0; multiple_of_n 0,1,1.
REQ-032 Scenario: N=3, LSB-first, bits 0,1,1 (value 6) -> remainder 0,2,0; multiple_of_n 1,0,1.
REQ-033 Scenario: start with in_valid=0 right after a divisible frame -> multiple_of_n=0 and bit_count=0 next cycle.
REQ-034 Scenario: reset=0 after 3 bits, then release -> all outputs 0; the next bit 1 with N=4 gives remainder=1 and bit_count=1.
REQ-035 Scenario: CNT_W=2, 5 accepted bits -> bit_count sticks at 3, overflow=1 from the 3rd bit, and start clears overflow.
